// File: rtl/ap_ctrl_hs_driver.sv
// Initiator for the HLS ap_ctrl_hs block handshake: one job in flight,
// result returned with start-to-done latency and a watchdog abort.
module ap_ctrl_hs_driver #(
    parameter int DATA_W  = 16,
    parameter int RES_W   = 16,
    parameter int LAT_W   = 16,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [DATA_W-1:0] job_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [LAT_W-1:0]  res_latency,
    output logic              res_timeout,
    output logic              ap_start,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              ap_idle,
    output logic              ap_continue,
    output logic [DATA_W-1:0] ap_x,
    input  logic [RES_W-1:0]  ap_return,
    output logic              busy,
    output logic [CNT_W-1:0]  job_count
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    localparam logic [LAT_W-1:0] LAT_MAX = '1;
    localparam logic [LAT_W-1:0] TO_VAL  = LAT_W'(TIMEOUT);

    state_t           state;
    logic [LAT_W-1:0] lat;
    logic [LAT_W-1:0] lat_nx;
    logic             run;
    logic             wd_fire;
    logic             unused_idle;

    // ap_idle is status only; sequencing relies on ap_ready/ap_done
    assign unused_idle = ap_idle;

    assign run     = (state == START) || (state == WAIT);
    assign lat_nx  = (lat == LAT_MAX) ? lat : lat + LAT_W'(1);
    assign wd_fire = (TIMEOUT != 0) && run && (lat == TO_VAL) && !ap_done;

    assign ap_continue = res_valid & res_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            lat         <= '0;
            job_ready   <= 1'b1;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_latency <= '0;
            res_timeout <= 1'b0;
            ap_start    <= 1'b0;
            ap_x        <= '0;
            busy        <= 1'b0;
            job_count   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (job_valid) begin
                        state     <= START;
                        ap_x      <= job_data;
                        lat       <= LAT_W'(1);
                        ap_start  <= 1'b1;
                        job_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START, WAIT: begin
                    lat <= lat_nx;
                    if (ap_done) begin
                        state       <= RESP;
                        res_data    <= ap_return;
                        res_latency <= lat;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        ap_start    <= 1'b0;
                    end else if (wd_fire) begin
                        state       <= RESP;
                        res_data    <= '0;
                        res_latency <= TO_VAL;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        ap_start    <= 1'b0;
                    end else if (state == START && ap_ready) begin
                        state    <= WAIT;
                        ap_start <= 1'b0;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        state       <= IDLE;
                        job_count   <= job_count + CNT_W'(1);
                        res_valid   <= 1'b0;
                        res_timeout <= 1'b0;
                        job_ready   <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
